// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer.
// Builds the 40-word key schedule one word per cycle. It borrows the shared
// S-box through sub_req/sub_gnt and streams round keys 0..10 over rk_valid/rk_ready.
// Optional build macro: AES_KEYEXP_RESTART_EN. When it is defined, a start
// while busy aborts the running expansion and reloads the new key.
module aes_key_expand_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_key,
  output logic         done,
  output logic         sub_req,
  input  logic         sub_gnt,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_EXPAND = 2'd2,
    S_FINISH = 2'd3
  } state_e;

`ifdef AES_KEYEXP_RESTART_EN
  localparam logic RESTART_EN = 1'b1;
`else
  localparam logic RESTART_EN = 1'b0;
`endif

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] val;
    case (rnd)
      4'd1:    val = 8'h01;
      4'd2:    val = 8'h02;
      4'd3:    val = 8'h04;
      4'd4:    val = 8'h08;
      4'd5:    val = 8'h10;
      4'd6:    val = 8'h20;
      4'd7:    val = 8'h40;
      4'd8:    val = 8'h80;
      4'd9:    val = 8'h1b;
      4'd10:   val = 8'h36;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // aesRotateWord: cyclic left rotate by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  state_e           state_q, state_d;
  logic [3:0][31:0] w_q, w_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       j_q, j_d;
  logic [127:0]     rk_key_q, rk_key_d;
  logic [3:0]       rk_round_q, rk_round_d;
  logic             busy_q, busy_d;
  logic             rk_valid_q, rk_valid_d;
  logic             done_q, done_d;
  logic             sub_req_q, sub_req_d;
  logic             disable_rotate_s;
  logic [31:0]      rot_out_s;
  logic [31:0]      new_word_s;
  logic             load_s;

  // Shared rotate unit: rotates W3 only in the first word step of a round.
  always_comb begin
    disable_rotate_s = !((state_q == S_EXPAND) && (j_q == 2'd0));
    if (disable_rotate_s) begin
      rot_out_s = w_q[3];
    end else begin
      rot_out_s = rot_word(w_q[3]);
    end
  end

  // New schedule word for the current step j.
  always_comb begin
    new_word_s = 32'h0000_0000;
    case (j_q)
      2'd0:    new_word_s = w_q[0] ^ sub_out ^ {rcon(round_q + 4'd1), 24'h00_0000};
      2'd1:    new_word_s = w_q[1] ^ w_q[0];
      2'd2:    new_word_s = w_q[2] ^ w_q[1];
      2'd3:    new_word_s = w_q[3] ^ w_q[2];
      default: new_word_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic: key load, emit handshake, and in-place word expansion.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    round_d    = round_q;
    j_d        = j_q;
    rk_key_d   = rk_key_q;
    rk_round_d = rk_round_q;
    load_s     = start && ((state_q == S_IDLE) || RESTART_EN);
    if (load_s) begin
      w_d[0]     = key_in[127:96];
      w_d[1]     = key_in[95:64];
      w_d[2]     = key_in[63:32];
      w_d[3]     = key_in[31:0];
      round_d    = 4'd0;
      j_d        = 2'd0;
      rk_key_d   = key_in;
      rk_round_d = 4'd0;
      state_d    = S_EMIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (round_q == LAST_ROUND) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_EXPAND;
              j_d     = 2'd0;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        S_EXPAND: begin
          // Step j=0 needs the S-box; without a grant nothing moves.
          if ((j_q != 2'd0) || sub_gnt) begin
            w_d[j_q] = new_word_s;
            if (j_q == 2'd3) begin
              state_d    = S_EMIT;
              j_d        = 2'd0;
              round_d    = round_q + 4'd1;
              rk_round_d = round_q + 4'd1;
              rk_key_d   = {w_q[0], w_q[1], w_q[2], new_word_s};
            end else begin
              j_d = j_q + 2'd1;
            end
          end else begin
            state_d = S_EXPAND;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d     = (state_d != S_IDLE);
    rk_valid_d = (state_d == S_EMIT);
    done_d     = (state_d == S_FINISH);
    sub_req_d  = (state_d == S_EXPAND) && (j_d == 2'd0);
  end

  // State, key window and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      w_q        <= '{default: 32'h0000_0000};
      round_q    <= 4'd0;
      j_q        <= 2'd0;
      rk_key_q   <= 128'h0;
      rk_round_q <= 4'd0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      sub_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      round_q    <= round_d;
      j_q        <= j_d;
      rk_key_q   <= rk_key_d;
      rk_round_q <= rk_round_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      sub_req_q  <= sub_req_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_key   = rk_key_q;
  assign done     = done_q;
  assign sub_req  = sub_req_q;
  assign sub_in   = rot_out_s;

endmodule

// File: doc/aes_key_expand_ctrl.md
# aes_key_expand_ctrl

Sequencer for AES-128 key expansion. It runs the 40-word key schedule one word per cycle and drives the shared rotate unit (`aesRotateWord`) internally. It borrows the datapath's S-box through a request/grant port and emits the 11 round keys in order over a valid/ready stream. It sits between the key-load logic and the round datapath.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately
- `start`  in  1  one-cycle request to expand `key_in`
- `key_in`  in  128  cipher key; `w0` = `[127:96]`; sampled on the accepted `start` cycle only
- `busy`  out  1  high in any state other than IDLE
- `rk_valid`  out  1  round key available
- `rk_ready`  in  1  consumer accepts; a transfer happens when `rk_valid && rk_ready`
- `rk_round`  out  4  round index 0..10 of `rk_key`
- `rk_key`  out  128  round key, `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`
- `done`  out  1  one-cycle pulse after the round-10 transfer
- `sub_req`  out  1  requests the shared S-box
- `sub_gnt`  in  1  S-box granted this cycle
- `sub_in`  out  32  word presented to the S-box (rotate-unit output)
- `sub_out`  in  32  combinational SubWord(`sub_in`)

## Operation
- States: IDLE, EMIT, EXPAND, FINISH.
- IDLE:
  - `start` latches `key_in` into the four-word window `W[0..3]`.
  - Sets round=0 and goes to EMIT.
- EMIT:
  - `rk_valid`=1; `rk_key`={W0..W3}; `rk_round`=round.
  - On transfer with round<10: go to EXPAND with word counter j=0.
  - On transfer with round=10: go to FINISH.
- EXPAND, one new word per cycle, j=0..3:
  - j=0:
    - Rotate enabled on W3, so `sub_in`=RotWord(W3), and `sub_req`=1.
    - If `sub_gnt`=0, stall: no state change and `sub_req` stays high.
    - If `sub_gnt`=1: new = W0 ^ `sub_out` ^ {Rcon[round+1], 24'h0}.
  - j=1..3: `disableRotate`=1, `sub_req`=0, new = W[j] ^ previous new word.
  - New words are written in place into `W[j]`.
  - After j=3: round increments and the FSM returns to EMIT.
- Rcon sequence for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- All XOR is 32-bit bitwise; counters are 4-bit (round) and 2-bit (j), with no wrap past 10.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `sub_in` is driven from the rotate output at all times. `sub_req` is high only in EXPAND with j=0.
- `start` while `busy` is handled as described under Configuration.
- `rk_ready` has no effect outside EMIT.

## Timing
- Reset values:
  - `busy`, `rk_valid`, `done`, `sub_req` = 0.
  - `rk_round` = 0; `rk_key` = 0.
  - W, round and j cleared; state IDLE.
- Latency:
  - `start` accepted in cycle 0 gives `rk_valid` in cycle 1 with round 0 (= `key_in`).
  - After a round-r transfer in cycle t, with `sub_gnt` held high, round r+1 is valid in cycle t+5 (EXPAND occupies t+1..t+4).
  - Each cycle that `sub_gnt` is low in EXPAND j=0 adds one cycle.
- With `rk_ready`=1 and `sub_gnt`=1 throughout:
  - Round r is valid in cycle 1+5r, so round 10 is valid in cycle 51.
  - `done` is high in cycle 52 and IDLE is reached in cycle 53.
- Backpressure: while `rk_valid`=1 and `rk_ready`=0, `rk_key` and `rk_round` hold stable and `rk_valid` stays high.
- `rk_key` and `rk_round` hold their last values outside EMIT.
- Reset asserted mid-EXPAND or mid-EMIT: all outputs are at reset values in the same cycle, and no partial key is emitted afterwards.

## Configuration
- `AES_KEYEXP_RESTART_EN` defined:
  - `start` while busy aborts the current expansion.
  - The new key is latched and the FSM enters EMIT at round 0 the next cycle.
  - No `done` pulse for the aborted key.
- `AES_KEYEXP_RESTART_EN` undefined: `start` while busy is ignored and the current expansion completes unchanged.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `rk_ready`=1, `sub_gnt`=1:
  - Round 0 = key in cycle 1.
  - Round 1 = `a0fafe1788542cb123a339392a6c7605` in cycle 6.
  - Round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` in cycle 51.
  - `done` in cycle 52.
- Same key, `sub_gnt` held low for 3 cycles at round-1 j=0:
  - `sub_req` stays high and `sub_in`=`cf4f3c09` throughout the stall.
  - Round 1 valid in cycle 9 with an unchanged value.
- `rk_ready` low for 4 cycles at round 5:
  - `rk_key` and `rk_round`=5 are stable throughout.
  - Round 6 is valid 5 cycles after the eventual transfer.
- Reset pulsed during round-3 EXPAND:
  - Outputs are 0 immediately and `busy`=0.
  - A fresh `start` restarts the expansion with round 0 one cycle later.
- `start` with key `000102030405060708090a0b0c0d0e0f` issued at round 4:
  - With `AES_KEYEXP_RESTART_EN`: the next `rk_valid` is round 0 = the new key, and no `done` occurs for the first key.
  - Without it: the original schedule completes to round 10 and `done` pulses once.
- Exhaustive Rcon check: `rk_key[127:120]` across rounds 1..10 for the all-zero key matches the FIPS-197 reference model.
